// File: rtl/debounce_pkg.sv
// Shared definitions for the push-button debouncer: FSM state encoding,
// default debounce depth and counter sizing helper.
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    RISE_WAIT = 2'b01,
    HIGH      = 2'b10,
    FALL_WAIT = 2'b11
  } db_state_t;

  localparam int unsigned DB_CYCLES_DEFAULT = 4;

  // Counter only needs to reach cycles-1; keep at least one bit.
  function automatic int unsigned cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync2 (
  input  logic rst,
  input  logic clk,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/debounce_pulse.sv
// Push-button debouncer: synchronises btn, accepts a level change after
// DB_CYCLES+1 stable samples and emits a one-cycle pulse per accepted press.
module debounce_pulse
  import debounce_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       pulse,
  output logic       level,
  output logic [1:0] st
);

  localparam int unsigned   CW       = cnt_width(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          s;
  db_state_t     state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          accept;

  sync2 u_sync (
    .rst (rst),
    .clk (clk),
    .d   (btn),
    .q   (s)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      pulse <= accept;
      // Registered from the next state so level rises together with pulse.
      level <= (state_n == HIGH) || (state_n == FALL_WAIT);
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    accept  = 1'b0;
    unique case (state)
      IDLE: begin
        if (s) begin
          state_n = RISE_WAIT;
          cnt_n   = '0;
        end
      end
      RISE_WAIT: begin
        if (!s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n = HIGH;
          accept  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HIGH: begin
        if (!s) begin
          state_n = FALL_WAIT;
          cnt_n   = '0;
        end
      end
      FALL_WAIT: begin
        if (s) begin
          state_n = HIGH;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign st = state;

endmodule

// File: tb/tb_debounce_pulse.sv
// Scoreboard bench for debounce_pulse driving a downstream m/n toggle FSM.
module tb_debounce_pulse;

  localparam int DB = 4;

  typedef struct {
    int   edge_n;
    logic val;
  } lvl_ev_t;

  logic       clk;
  logic       rst;
  logic       btn;
  logic       pulse;
  logic       level;
  logic [1:0] st;
  logic [2:0] y;

  int      cyc;
  int      n_chk;
  int      n_fail;
  int      pulse_cnt;
  int      exp_y;
  logic    prev_level;
  logic    saw_fall;
  int      pulse_q[$];
  lvl_ev_t lvl_q[$];

  debounce_pulse #(.DB_CYCLES(DB)) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .pulse (pulse),
    .level (level),
    .st    (st)
  );

  // Downstream toggle FSM: y alternates m=5 / n=2 on each i (= pulse).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       y <= 3'd5;
    else if (pulse) y <= (y == 3'd5) ? 3'd2 : 3'd5;
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic hold(input logic v, input int n);
    btn = v;
    repeat (n) @(negedge clk);
  endtask

  // Called at a negedge just before driving btn high/low for a long hold.
  task automatic expect_press();
    int e;
    e = cyc + 1 + DB + 2;
    pulse_q.push_back(e);
    lvl_q.push_back('{e, 1'b1});
    exp_y = (exp_y == 5) ? 2 : 5;
  endtask

  task automatic expect_release();
    lvl_q.push_back('{cyc + 1 + DB + 2, 1'b0});
  endtask

  always @(negedge clk) begin : monitor
    int      e;
    lvl_ev_t ev;
    if (st === 2'b11) saw_fall = 1'b1;
    if (pulse === 1'b1) begin
      pulse_cnt++;
      if (pulse_q.size() == 0) begin
        chk("spurious_pulse", cyc, -1);
      end else begin
        e = pulse_q.pop_front();
        chk("pulse_edge", cyc, e);
      end
    end
    if (level !== prev_level) begin
      if (lvl_q.size() == 0) begin
        chk("spurious_level", level, prev_level);
      end else begin
        ev = lvl_q.pop_front();
        chk("level_edge", cyc, ev.edge_n);
        chk("level_val", level, ev.val);
      end
      prev_level = level;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached at edge %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    pulse_cnt  = 0;
    exp_y      = 5;
    prev_level = 1'b0;
    saw_fall   = 1'b0;
    rst        = 1'b0;
    btn        = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_pulse", pulse, 0);
    chk("rst_level", level, 0);
    chk("rst_st", st, 2'b00);
    chk("rst_y", y, 5);
    rst = 1'b1;

    // Clean press first sampled at edge 10, held 100 cycles.
    while (cyc < 9) @(negedge clk);
    expect_press();
    chk("press_edge_16", pulse_q[0], 16);
    hold(1'b1, 100);
    chk("one_pulse_100", pulse_cnt, 1);
    chk("level_held", level, 1);
    chk("y_after_press", y, exp_y);
    expect_release();
    hold(1'b0, 20);
    chk("level_released", level, 0);

    // Bounce on the way in.
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 2);
    hold(1'b0, 1);
    expect_press();
    hold(1'b1, 20);
    chk("bounce_one_pulse", pulse_cnt, 2);
    chk("y_after_bounce", y, exp_y);

    // Short release glitch while HIGH.
    saw_fall = 1'b0;
    hold(1'b0, 2);
    hold(1'b1, 20);
    chk("glitch_saw_fall_wait", saw_fall, 1);
    chk("glitch_level", level, 1);
    chk("glitch_no_pulse", pulse_cnt, 2);
    chk("glitch_st_high", st, 2'b10);
    expect_release();
    hold(1'b0, 20);

    // Three full press/release cycles.
    for (int i = 0; i < 3; i++) begin
      expect_press();
      hold(1'b1, 20);
      chk("cycle_y", y, exp_y);
      expect_release();
      hold(1'b0, 20);
      chk("cycle_level_low", level, 0);
    end
    chk("cycle_pulses", pulse_cnt, 5);

    // Asynchronous reset while in RISE_WAIT with cnt=2.
    hold(1'b1, 5);
    chk("pre_rst_st", st, 2'b01);
    chk("pre_rst_cnt", dut.cnt, 2);
    #2 rst = 1'b0;
    #1;
    chk("async_st", st, 2'b00);
    chk("async_level", level, 0);
    chk("async_pulse", pulse, 0);
    chk("async_y", y, 5);
    exp_y = 5;
    repeat (3) @(negedge clk);
    chk("rst_held_pulses", pulse_cnt, 5);
    expect_press();
    rst = 1'b1;
    hold(1'b1, 20);
    chk("post_rst_pulses", pulse_cnt, 6);
    chk("post_rst_y", y, exp_y);
    expect_release();
    hold(1'b0, 20);

    chk("pulse_q_drained", pulse_q.size(), 0);
    chk("level_q_drained", lvl_q.size(), 0);
    chk("final_level", level, 0);
    chk("final_st", st, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
